// File: rtl/secded_pkg.sv
// secded_pkg: SECDED sizing, codeword layout, encoder, syndrome masks and injection modes
package secded_pkg;
   localparam int CW_MAX = 72;
   typedef enum logic [1:0] {
      INJ_NONE   = 2'b00,
      INJ_SINGLE = 2'b01,
      INJ_DOUBLE = 2'b10,
      INJ_PARITY = 2'b11
   } inj_e;
   function automatic int secded_p(input int width);
      int p;
      p = 0;
      for (int i = 7; i >= 1; i--) if ((1 << i) >= width + i + 1) p = i;
      return p;
   endfunction
   // Vector index of data bit j: data fills the non-power-of-two Hamming positions in order
   function automatic int secded_dpos(input int j);
      int r, n;
      r = 0;
      n = 0;
      for (int k = 0; k < CW_MAX - 1; k++)
         if (((k + 1) & k) != 0) begin
            if (n == j) r = k;
            n++;
         end
      return r;
   endfunction
   // Bits covered by parity bit i: Hamming positions with bit i set, overall parity excluded
   function automatic logic [CW_MAX-1:0] secded_mask(input int width, input int i);
      logic [CW_MAX-1:0] m;
      m = '0;
      for (int k = 0; k < CW_MAX - 1; k++) m[k] = (k < width + secded_p(width)) && (((k + 1) >> i) & 1) != 0;
      return m;
   endfunction
   function automatic logic [CW_MAX-1:0] secded_enc(input int width, input logic [63:0] data);
      logic [CW_MAX-1:0] c;
      int p;
      c = '0;
      p = secded_p(width);
      for (int j = 0; j < 64; j++) if (j < width) c[secded_dpos(j)] = data[j];
      for (int i = 0; i < 7; i++) if (i < p) c[(1 << i) - 1] = ^(c & secded_mask(width, i));
      c[width + p] = ^c;
      return c;
   endfunction
endpackage

// File: rtl/secded_fifo_param_if.sv
// secded_fifo_param_if: write, read and status bundle of the SECDED FIFO
interface secded_fifo_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 8
);
   logic wr_valid, wr_ready, rd_valid, rd_ready, rd_single, rd_double, cnt_clr;
   logic [DATA_WIDTH-1:0] wr_data, rd_data;
   logic [1:0] inj_mode;
   logic [CNT_WIDTH-1:0] cnt_single, cnt_double;
   logic [$clog2(DEPTH):0] level;
   modport master (
      output wr_valid, wr_data, inj_mode, rd_ready, cnt_clr,
      input  wr_ready, rd_valid, rd_data, rd_single, rd_double, cnt_single, cnt_double, level
   );
   modport slave (
      input  wr_valid, wr_data, inj_mode, rd_ready, cnt_clr,
      output wr_ready, rd_valid, rd_data, rd_single, rd_double, cnt_single, cnt_double, level
   );
endinterface

// File: rtl/secded_dec_param.sv
// secded_dec_param: combinational SECDED decode with single correction and double detection
module secded_dec_param
   import secded_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   localparam int P  = secded_p(DATA_WIDTH),
   localparam int CW = DATA_WIDTH + P + 1
) (
   input  logic [CW-1:0]         cw_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  single_o,
   output logic                  double_o
);
   logic [CW_MAX-1:0] ext;
   logic [P-1:0] syn;
   logic mism, in_range;
   // Syndrome plus overall parity classify the word; only an in-range single error is flipped back
   always_comb begin
      ext = '0;
      ext[CW-1:0] = cw_i;
      for (int i = 0; i < P; i++) syn[i] = ^(ext & secded_mask(DATA_WIDTH, i));
      mism = ^cw_i;
      in_range = int'(syn) < CW;
      single_o = mism && in_range;
      double_o = syn != '0 && (!mism || !in_range);
      for (int j = 0; j < DATA_WIDTH; j++)
         data_o[j] = cw_i[secded_dpos(j)] ^ (mism && int'(syn) == secded_dpos(j) + 1);
   end
endmodule

// File: rtl/secded_fifo_param.sv
// secded_fifo_param: SECDED-protected FIFO with ready/valid ports, error injection and error counters
module secded_fifo_param
   import secded_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 8,
   parameter int INJ_POS0   = 2,
   parameter int INJ_POS1   = 4
) (
   input logic clk,
   input logic rst_n,
   secded_fifo_param_if.slave bus
);
   localparam int P  = secded_p(DATA_WIDTH);
   localparam int CW = DATA_WIDTH + P + 1;
   localparam int AW = $clog2(DEPTH);
   logic [CW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0] level_q, level_d;
   logic [CW-1:0] inj_mask, wr_word;
   logic wr_rdy, push, load, dec_single, dec_double;
   logic [DATA_WIDTH-1:0] dec_data, rd_data_q;
   logic rd_valid_q, rd_single_q, rd_double_q;
   logic [CNT_WIDTH-1:0] cnt_single_q, cnt_double_q;
   assign wr_rdy  = level_q != (AW + 1)'(DEPTH);
   assign push    = bus.wr_valid && wr_rdy;
   assign load    = level_q != '0 && (!rd_valid_q || bus.rd_ready);
   assign level_d = level_q + (AW + 1)'(push) - (AW + 1)'(load);
   assign wr_word = CW'(secded_enc(DATA_WIDTH, 64'(bus.wr_data))) ^ inj_mask;
   assign bus.wr_ready   = wr_rdy;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.rd_single  = rd_single_q;
   assign bus.rd_double  = rd_double_q;
   assign bus.cnt_single = cnt_single_q;
   assign bus.cnt_double = cnt_double_q;
   assign bus.level      = level_q;
   // Injection mask flips chosen codeword bits of the word being written
   always_comb begin
      inj_mask = '0;
      inj_mask[INJ_POS0] = bus.inj_mode == INJ_SINGLE || bus.inj_mode == INJ_DOUBLE;
      inj_mask[INJ_POS1] = bus.inj_mode == INJ_DOUBLE;
      inj_mask[CW-1] = bus.inj_mode == INJ_PARITY;
   end
   // Storage array is not reset; only entries below level are ever decoded
   always_ff @(posedge clk) if (push) mem_q[wptr_q] <= wr_word;
   secded_dec_param #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
      .cw_i(mem_q[rptr_q]), .data_o(dec_data), .single_o(dec_single), .double_o(dec_double)
   );
   // Pointers, occupancy, output register and saturating error counters
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         level_q <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q <= '0;
         rd_single_q <= 1'b0;
         rd_double_q <= 1'b0;
         cnt_single_q <= '0;
         cnt_double_q <= '0;
      end else begin
         wptr_q <= wptr_q + AW'(push);
         rptr_q <= rptr_q + AW'(load);
         level_q <= level_d;
         rd_valid_q <= load || (rd_valid_q && !bus.rd_ready);
         if (load) begin
            rd_data_q <= dec_data;
            rd_single_q <= dec_single;
            rd_double_q <= dec_double;
         end
         cnt_single_q <= bus.cnt_clr ? '0 : cnt_single_q + CNT_WIDTH'(load && dec_single && !(&cnt_single_q));
         cnt_double_q <= bus.cnt_clr ? '0 : cnt_double_q + CNT_WIDTH'(load && dec_double && !(&cnt_double_q));
      end
endmodule

// File: tb/tb_secded_fifo_param.sv
// tb_secded_fifo_param: directed 8-bit checks plus a randomized 32-bit scoreboard run
module tb_secded_fifo_param;
   import secded_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int compared = 0;
   int mismatched = 0;
   always #5 clk = ~clk;
   secded_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(2)) a ();
   secded_fifo_param_if #(.DATA_WIDTH(32), .DEPTH(8), .CNT_WIDTH(12)) b ();
   secded_fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
   secded_fifo_param #(.DATA_WIDTH(32), .DEPTH(8), .CNT_WIDTH(12)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic a_write(input logic [7:0] d, input logic [1:0] m);
      a.wr_valid = 1'b1;
      a.wr_data = d;
      a.inj_mode = m;
      tick();
      a.wr_valid = 1'b0;
   endtask
   // Expected read-side view of a written word: {single, double, data}
   function automatic logic [33:0] expect_word(input logic [31:0] d, input logic [1:0] m);
      return m == 2'b10 ? {2'b01, d ^ 32'h3} : {m == 2'b01 || m == 2'b11, 1'b0, d};
   endfunction
   initial begin
      logic [33:0] q[$];
      logic [33:0] held, e;
      logic held_v;
      int sent, exp_s, exp_d;
      a.wr_valid = 0; a.wr_data = 0; a.inj_mode = 0; a.rd_ready = 0; a.cnt_clr = 0;
      b.wr_valid = 0; b.wr_data = 0; b.inj_mode = 0; b.rd_ready = 0; b.cnt_clr = 0;
      tick();
      tick();
      chk("rst_a_rd_valid", a.rd_valid, 0);
      chk("rst_a_level", a.level, 0);
      chk("rst_a_wr_ready", a.wr_ready, 1);
      chk("rst_a_rd_data", a.rd_data, 0);
      chk("rst_a_cnt", {a.cnt_single, a.cnt_double}, 0);
      chk("rst_b_rd_valid", b.rd_valid, 0);
      chk("rst_b_wr_ready", b.wr_ready, 1);
      rst_n = 1'b1;
      chk("enc_a5", 64'(secded_enc(8, 64'hA5)), 64'h0A27);
      a.rd_ready = 1'b1;
      a_write(8'hA5, 2'b00);
      chk("clean_latency", a.rd_valid, 0);
      tick();
      chk("clean_valid", a.rd_valid, 1);
      chk("clean_word", {a.rd_single, a.rd_double, a.rd_data}, {2'b00, 8'hA5});
      tick();
      chk("release", a.rd_valid, 0);
      a_write(8'hA5, 2'b01);
      tick();
      chk("single_word", {a.rd_single, a.rd_double, a.rd_data}, {2'b10, 8'hA5});
      chk("single_cnt", a.cnt_single, 1);
      tick();
      a_write(8'hA5, 2'b11);
      tick();
      chk("parity_word", {a.rd_single, a.rd_double, a.rd_data}, {2'b10, 8'hA5});
      chk("parity_cnt", a.cnt_single, 2);
      tick();
      a_write(8'h3C, 2'b10);
      tick();
      chk("double_word", {a.rd_single, a.rd_double, a.rd_data}, {2'b01, 8'h3F});
      chk("double_cnt", a.cnt_double, 1);
      tick();
      for (int i = 0; i < 3; i++) a_write(8'h50 + 8'(i), 2'b01);
      tick();
      tick();
      chk("sat_cnt", a.cnt_single, 3);
      a.cnt_clr = 1'b1;
      tick();
      a.cnt_clr = 1'b0;
      chk("clr_cnt", {a.cnt_single, a.cnt_double}, 0);
      a.rd_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         a.wr_valid = 1'b1;
         a.wr_data = 8'h10 + 8'(i);
         a.inj_mode = 2'b00;
         chk($sformatf("full_wr_ready%0d", i), a.wr_ready, i < 5);
         tick();
      end
      a.wr_valid = 1'b0;
      chk("full_level", a.level, 4);
      chk("full_wr_ready", a.wr_ready, 0);
      a.rd_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("drain_valid%0d", k), a.rd_valid, 1);
         chk($sformatf("drain_data%0d", k), a.rd_data, 8'h10 + 8'(k));
         tick();
      end
      chk("drain_empty", a.rd_valid, 0);
      chk("drain_level", a.level, 0);
      sent = 0; exp_s = 0; exp_d = 0; held_v = 1'b0; held = '0;
      for (int cyc = 0; cyc < 20000 && (sent < 1000 || q.size() != 0 || b.rd_valid); cyc++) begin
         if (held_v) begin
            chk("hold_valid", b.rd_valid, 1);
            chk("hold_word", {b.rd_single, b.rd_double, b.rd_data}, held);
         end
         chk("occupancy", int'(b.level) + int'(b.rd_valid), q.size());
         b.rd_ready = $urandom_range(0, 3) != 0;
         b.wr_valid = sent < 1000 && $urandom_range(0, 1) == 1;
         b.wr_data = $urandom;
         b.inj_mode = 2'($urandom_range(0, 3));
         held_v = 1'b0;
         if (b.rd_valid && b.rd_ready) begin
            e = q.size() != 0 ? q.pop_front() : 34'h3_FFFF_FFFF;
            chk("rand_word", {b.rd_single, b.rd_double, b.rd_data}, e);
         end else if (b.rd_valid) begin
            held_v = 1'b1;
            held = {b.rd_single, b.rd_double, b.rd_data};
         end
         if (b.wr_valid && b.wr_ready) begin
            q.push_back(expect_word(b.wr_data, b.inj_mode));
            sent++;
            exp_s += int'(b.inj_mode == 2'b01 || b.inj_mode == 2'b11);
            exp_d += int'(b.inj_mode == 2'b10);
         end
         tick();
      end
      b.wr_valid = 1'b0;
      chk("rand_done", sent == 1000 && q.size() == 0 && !b.rd_valid, 1);
      chk("rand_cnt_single", b.cnt_single, exp_s);
      chk("rand_cnt_double", b.cnt_double, exp_d);
      a.rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) a_write(8'h70 + 8'(i), 2'b00);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rd_valid", a.rd_valid, 0);
      chk("midrst_level", a.level, 0);
      chk("midrst_wr_ready", a.wr_ready, 1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", a.rd_valid, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
